// File: rtl/flash_req_arbiter_if.sv
// Handshake bundle shared by the two requesters, the arbiter and the flash read FSM.
interface flash_req_arbiter_if #(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              flash_start;
    logic [ADDR_W-1:0] flash_addr;
    logic              flash_finish;
    logic [DATA_W-1:0] flash_data;

    // Arbiter side
    modport slave (
        input  req0, req1, addr0, addr1, flash_finish, flash_data,
        output gnt0, gnt1, done0, done1, err, rdata, busy, flash_start, flash_addr
    );

    // Requesters and flash read FSM side
    modport master (
        output req0, req1, addr0, addr1, flash_finish, flash_data,
        input  gnt0, gnt1, done0, done1, err, rdata, busy, flash_start, flash_addr
    );
endinterface

// File: rtl/flash_req_arbiter.sv
// Two-requester round-robin arbiter in front of a flash read FSM, with a
// bounded wait for the flash to finish and an error flag on timeout.
module flash_req_arbiter #(
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                clk,
    input logic                rst,
    flash_req_arbiter_if.slave bus
);
    localparam int unsigned      TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             take;        // a request wins arbitration this cycle
    logic             win;         // index of the winning requester
    logic             owner;       // requester holding the current grant
    logic             last_grant;  // requester served by the last completed transaction
    logic [TMR_W-1:0] timer;

    // State register; reset forces IDLE from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration, next-state logic and outputs decoded from state/registers only
    always_comb begin
        state_next      = state;
        take            = 1'b0;
        win             = 1'b0;
        bus.flash_start = 1'b0;
        bus.done0       = 1'b0;
        bus.done1       = 1'b0;
        bus.busy        = 1'b0;
        bus.gnt0        = 1'b0;
        bus.gnt1        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    take = 1'b1;
                    win  = ~last_grant;
                end else if (bus.req0) begin
                    take = 1'b1;
                    win  = 1'b0;
                end else if (bus.req1) begin
                    take = 1'b1;
                    win  = 1'b1;
                end
                if (take) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                bus.flash_start = 1'b1;
                state_next      = WAIT;
            end
            WAIT: begin
                if (bus.flash_finish || (timer == TMR_LAST)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.done0  = ~owner;
                bus.done1  = owner;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state != IDLE) begin
            bus.busy = 1'b1;
            bus.gnt0 = ~owner;
            bus.gnt1 = owner;
        end
    end

    // Grant owner, address latch, wait timer, read data and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            timer          <= '0;
            bus.flash_addr <= '0;
            bus.rdata      <= '0;
            bus.err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        owner          <= win;
                        bus.flash_addr <= win ? bus.addr1 : bus.addr0;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    // finish outranks the timeout terminal; the timer saturates there
                    if (bus.flash_finish) begin
                        bus.rdata <= bus.flash_data;
                        bus.err   <= 1'b0;
                    end else if (timer == TMR_LAST) begin
                        bus.err <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                DONE: last_grant <= owner;
                default: ;
            endcase
        end
    end
endmodule
